mux_n_pipe: RTL and testbench
=============================

# mux_n_pipe

Parametrised, registered N-to-1 operand select for the CPU datapath. It generalises the 3-input combinational select to NUM_INPUTS channels, and each select decision travels as a beat through a valid/ready pipeline stage with a skid entry, so a stalled consumer never forces a combinational ready path back to the producer. It also flags out-of-range selects per beat and stickily, and supports a pipeline flush for branch or exception squash.

## Interface
- WORD_SIZE, 32, data width per channel
- NUM_INPUTS, 4, number of input channels; must be at least 2
- SEL_WIDTH, $clog2(NUM_INPUTS), select width; derived, never overridden

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- sel  in  SEL_WIDTH  channel index for this beat
- data_in  in  NUM_INPUTS*WORD_SIZE  flattened channels; channel i occupies data_in[i*WORD_SIZE +: WORD_SIZE]
- flush  in  1  synchronous squash of all held beats
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts the beat
- out_data  out  WORD_SIZE  selected word
- out_sel_err  out  1  the current output beat had an illegal select
- sel_err_sticky  out  1  set by any accepted illegal select; cleared only by rst

## Operation
- Accept: in_valid && in_ready at a rising edge. The stage captures data_in channel sel together with err = (sel >= NUM_INPUTS).
- Illegal select: the captured word is all zeros and err is 1. There is no X propagation.
- Storage: a main register feeds the outputs. One skid entry holds a beat accepted while main is held.
- States: EMPTY (main invalid), HALF (main valid, skid empty), FULL (both valid).
- EMPTY, accept: HALF.
- HALF, accept and no drain: FULL.
- HALF, drain and no accept: EMPTY.
- HALF, accept and drain together: stays HALF; the new beat goes to main.
- FULL, drain: HALF; skid moves to main.
- FULL never accepts, because in_ready is 0.
- Drain: out_valid && out_ready at a rising edge.
- in_ready = !skid_valid && !rst. It depends only on registered state and has no path from out_ready.
- Order: strictly FIFO; beats are never reordered or duplicated.
- Flush has priority over every other event. At the edge: main and skid are invalidated, any beat accepted in the same cycle is discarded, and the stage goes to EMPTY. sel_err_sticky is not cleared. An illegal beat accepted in the flush cycle still sets sel_err_sticky.
- While out_valid && !out_ready, out_data and out_sel_err hold stable.

## Timing
- Reset, asynchronous, applied the moment rst rises: out_valid=0, out_data=0, out_sel_err=0, sel_err_sticky=0, skid cleared, state EMPTY.
- in_ready is 0 while rst is high.
- Reset mid-operation drops all beats immediately.
- Latency: a beat accepted at edge k is presented on out_valid/out_data during cycle k+1.
- Throughput: one beat per cycle sustained while out_ready=1.
- Backpressure: when out_ready falls, at most one more beat is accepted, into skid. in_ready is then 0 from the next cycle.
- After one drain from FULL, in_ready returns to 1 in the following cycle.
- sel_err_sticky rises in the cycle after the accepting edge.
- Flush asserted at edge k: out_valid=0 and in_ready=1 during cycle k+1.

## Test plan
- Streaming, NUM_INPUTS=4, out_ready=1. Beats sel=0,1,2,3 with channels 0x10,0x20,0x30,0x40 -> out_data 0x10,0x20,0x30,0x40 on four consecutive cycles, each one cycle after accept, with in_ready constantly 1.
- Backpressure. Hold out_ready=0 and offer three beats A,B,C -> A in main, B in skid, in_ready=0 and C held upstream. Release out_ready -> A, B, C emerge in order with no loss.
- Illegal select, NUM_INPUTS=3, sel=3, all channels 0xFFFFFFFF -> out_data=0, out_sel_err=1, sel_err_sticky=1. The following legal beat shows out_sel_err=0 while sel_err_sticky stays 1.
- Flush while FULL, plus a flush coinciding with an accept -> out_valid=0 and in_ready=1 the next cycle, and neither dropped beat ever appears.
- Asynchronous reset asserted mid-cycle while FULL -> out_valid, out_data, out_sel_err and sel_err_sticky all go to 0 without waiting for a clk edge, and in_ready=0 until rst deasserts.
- Parameter sweep NUM_INPUTS = 2, 5, 8 with random sel, valid and ready -> output stream matches a reference queue model, including err on every sel >= NUM_INPUTS.

Source files
------------

// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: upstream select/data beat, flush,
// downstream result beat and select-error flags.
interface mux_n_pipe_if #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_INPUTS = 4
);
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS);

  logic                            in_valid;
  logic                            in_ready;
  logic [SEL_WIDTH-1:0]            sel;
  logic [NUM_INPUTS*WORD_SIZE-1:0] data_in;
  logic                            flush;
  logic                            out_valid;
  logic                            out_ready;
  logic [WORD_SIZE-1:0]            out_data;
  logic                            out_sel_err;
  logic                            sel_err_sticky;

  modport master (
    output in_valid, sel, data_in, flush, out_ready,
    input  in_ready, out_valid, out_data, out_sel_err, sel_err_sticky
  );

  modport slave (
    input  in_valid, sel, data_in, flush, out_ready,
    output in_ready, out_valid, out_data, out_sel_err, sel_err_sticky
  );
endinterface

// File: rtl/mux_n_pipe.sv
// Registered N-to-1 operand select with a main register plus one skid entry,
// out-of-range select flagging and a synchronous flush.
module mux_n_pipe #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_INPUTS = 4    // must be at least 2
) (
  input  logic        clk,
  input  logic        rst,
  mux_n_pipe_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS);

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  typedef struct packed {
    logic                 err;
    logic [WORD_SIZE-1:0] data;
  } beat_t;

  state_t state;
  beat_t  main_q, skid_q, cap;
  logic   sticky_q;
  logic   accept, drain;

  // Out-of-range selects capture zero rather than an undefined channel.
  always_comb begin
    cap     = '0;
    cap.err = (32'(bus.sel) >= NUM_INPUTS);
    for (int i = 0; i < NUM_INPUTS; i++)
      if (bus.sel == SEL_WIDTH'(i))
        cap.data = bus.data_in[i*WORD_SIZE +: WORD_SIZE];
  end

  // Ready comes only from registered occupancy, never from out_ready.
  assign bus.in_ready = (state != FULL) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      // The sticky flag records illegal beats even if they are squashed.
      if (accept && cap.err) sticky_q <= 1'b1;
      if (bus.flush) begin
        state <= EMPTY;
      end else begin
        unique case (state)
          EMPTY: if (accept) begin
            main_q <= cap;
            state  <= HALF;
          end
          HALF: begin
            if (accept && drain) begin
              main_q <= cap;
            end else if (accept) begin
              skid_q <= cap;
              state  <= FULL;
            end else if (drain) begin
              state  <= EMPTY;
            end
          end
          FULL: if (drain) begin
            main_q <= skid_q;
            state  <= HALF;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign bus.out_valid      = (state != EMPTY);
  assign bus.out_data       = main_q.data;
  assign bus.out_sel_err    = main_q.err;
  assign bus.sel_err_sticky = sticky_q;
endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed and randomized checks of mux_n_pipe across several channel counts.
module tb_mux_n_pipe;
  logic clk, rst;
  int   total, passed;

  mux_n_pipe_if #(.WORD_SIZE(32), .NUM_INPUTS(4)) a ();
  mux_n_pipe_if #(.WORD_SIZE(32), .NUM_INPUTS(3)) b ();
  mux_n_pipe_if #(.WORD_SIZE(32), .NUM_INPUTS(2)) c2 ();
  mux_n_pipe_if #(.WORD_SIZE(32), .NUM_INPUTS(5)) c5 ();
  mux_n_pipe_if #(.WORD_SIZE(32), .NUM_INPUTS(8)) c8 ();

  mux_n_pipe #(.WORD_SIZE(32), .NUM_INPUTS(4)) u_a  (.clk(clk), .rst(rst), .bus(a));
  mux_n_pipe #(.WORD_SIZE(32), .NUM_INPUTS(3)) u_b  (.clk(clk), .rst(rst), .bus(b));
  mux_n_pipe #(.WORD_SIZE(32), .NUM_INPUTS(2)) u_c2 (.clk(clk), .rst(rst), .bus(c2));
  mux_n_pipe #(.WORD_SIZE(32), .NUM_INPUTS(5)) u_c5 (.clk(clk), .rst(rst), .bus(c5));
  mux_n_pipe #(.WORD_SIZE(32), .NUM_INPUTS(8)) u_c8 (.clk(clk), .rst(rst), .bus(c8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [32:0]  q [3][$];
  logic [32:0]  exp_b [3];
  logic         obs_rdy [3], obs_v [3];
  logic [32:0]  obs_b [3];
  logic [31:0]  w [8];
  logic [255:0] pk;
  logic [2:0]   s3;
  logic         v, r, acc;

  initial begin
    total = 0; passed = 0;
    rst = 1'b1;
    a.in_valid = 0;  a.sel = '0;  a.data_in = '0;  a.flush = 0;  a.out_ready = 0;
    b.in_valid = 0;  b.sel = '0;  b.data_in = '0;  b.flush = 0;  b.out_ready = 0;
    c2.in_valid = 0; c2.sel = '0; c2.data_in = '0; c2.flush = 0; c2.out_ready = 0;
    c5.in_valid = 0; c5.sel = '0; c5.data_in = '0; c5.flush = 0; c5.out_ready = 0;
    c8.in_valid = 0; c8.sel = '0; c8.data_in = '0; c8.flush = 0; c8.out_ready = 0;
    #1;
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_in_ready", a.in_ready, 0);
    chk("rst_out_data", a.out_data, 0);
    chk("rst_sticky", b.sel_err_sticky, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", a.in_ready, 1);

    // Streaming
    a.data_in = {32'h40, 32'h30, 32'h20, 32'h10};
    a.out_ready = 1; a.in_valid = 1;
    for (int s = 0; s < 4; s++) begin
      a.sel = 2'(s);
      chk("stream_in_ready", a.in_ready, 1);
      step();
      chk("stream_valid", a.out_valid, 1);
      chk("stream_data", a.out_data, 64'((s + 1) * 16));
    end
    a.in_valid = 0;
    step();
    chk("stream_idle", a.out_valid, 0);

    // Backpressure: A to main, B to skid, C held upstream
    a.data_in = {32'h0, 32'hC3, 32'hB2, 32'hA1};
    a.out_ready = 0; a.in_valid = 1; a.sel = 2'd0;
    step();
    chk("bp_a_data", a.out_data, 32'hA1);
    chk("bp_a_ready", a.in_ready, 1);
    a.sel = 2'd1;
    step();
    chk("bp_full_ready", a.in_ready, 0);
    chk("bp_hold_data", a.out_data, 32'hA1);
    a.sel = 2'd2;
    step();
    chk("bp_still_full", a.in_ready, 0);
    chk("bp_stable_data", a.out_data, 32'hA1);
    a.out_ready = 1;
    step();
    chk("bp_b_data", a.out_data, 32'hB2);
    chk("bp_ready_back", a.in_ready, 1);
    step();
    chk("bp_c_data", a.out_data, 32'hC3);
    chk("bp_c_valid", a.out_valid, 1);
    a.in_valid = 0;
    step();
    chk("bp_drained", a.out_valid, 0);

    // Illegal select with NUM_INPUTS=3
    b.data_in = {3{32'hFFFFFFFF}};
    b.out_ready = 1; b.in_valid = 1; b.sel = 2'd3;
    step();
    chk("ill_valid", b.out_valid, 1);
    chk("ill_data", b.out_data, 0);
    chk("ill_err", b.out_sel_err, 1);
    chk("ill_sticky", b.sel_err_sticky, 1);
    b.sel = 2'd1;
    step();
    chk("legal_data", b.out_data, 32'hFFFFFFFF);
    chk("legal_err", b.out_sel_err, 0);
    chk("legal_sticky", b.sel_err_sticky, 1);
    b.in_valid = 0;
    step();

    // Flush while FULL, then flush coinciding with an accept
    a.data_in = {32'hF1, 32'h77, 32'hE5, 32'hD4};
    a.out_ready = 0; a.in_valid = 1; a.sel = 2'd0;
    step();
    a.sel = 2'd1;
    step();
    chk("fl_full", a.in_ready, 0);
    a.in_valid = 0; a.flush = 1;
    step();
    a.flush = 0;
    chk("fl_valid", a.out_valid, 0);
    chk("fl_ready", a.in_ready, 1);
    a.in_valid = 1; a.sel = 2'd3; a.flush = 1;
    step();
    a.flush = 0; a.in_valid = 0;
    chk("fl_acc_valid", a.out_valid, 0);
    chk("fl_acc_ready", a.in_ready, 1);
    a.out_ready = 1; a.in_valid = 1; a.sel = 2'd2;
    step();
    a.in_valid = 0;
    chk("fl_next_data", a.out_data, 32'h77);
    step();
    chk("fl_no_ghost", a.out_valid, 0);

    // Async reset mid-cycle while FULL
    a.data_in = {32'h44, 32'h33, 32'h22, 32'h11};
    a.out_ready = 0; a.in_valid = 1; a.sel = 2'd0;
    b.out_ready = 0; b.in_valid = 1; b.sel = 2'd3;
    step();
    a.sel = 2'd1; b.sel = 2'd0;
    step();
    a.in_valid = 0; b.in_valid = 0;
    chk("ar_pre_full", a.in_ready, 0);
    chk("ar_pre_err", b.out_sel_err, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", a.out_valid, 0);
    chk("ar_data", a.out_data, 0);
    chk("ar_err", b.out_sel_err, 0);
    chk("ar_sticky", b.sel_err_sticky, 0);
    chk("ar_ready", a.in_ready, 0);
    step();
    chk("ar_ready_held", a.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("ar_ready_rel", a.in_ready, 1);

    // Illegal beat accepted in a flush cycle still sets the sticky flag
    c5.in_valid = 1; c5.sel = 3'd6; c5.flush = 1;
    step();
    c5.in_valid = 0; c5.flush = 0;
    chk("fl_ill_valid", c5.out_valid, 0);
    chk("fl_ill_sticky", c5.sel_err_sticky, 1);
    chk("fl_ill_ready", c5.in_ready, 1);

    // Random sweep against queue models
    for (int cyc = 0; cyc < 300; cyc++) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 3) != 0);
      s3 = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) begin
        w[k] = $urandom;
        pk[k*32 +: 32] = w[k];
      end
      c2.in_valid = v; c2.out_ready = r; c2.sel = s3[0]; c2.data_in = pk[63:0];
      c5.in_valid = v; c5.out_ready = r; c5.sel = s3;    c5.data_in = pk[159:0];
      c8.in_valid = v; c8.out_ready = r; c8.sel = s3;    c8.data_in = pk;
      exp_b[0] = {1'b0, w[s3[0]]};
      exp_b[1] = (s3 >= 3'd5) ? {1'b1, 32'h0} : {1'b0, w[s3]};
      exp_b[2] = {1'b0, w[s3]};
      obs_rdy[0] = c2.in_ready; obs_v[0] = c2.out_valid; obs_b[0] = {c2.out_sel_err, c2.out_data};
      obs_rdy[1] = c5.in_ready; obs_v[1] = c5.out_valid; obs_b[1] = {c5.out_sel_err, c5.out_data};
      obs_rdy[2] = c8.in_ready; obs_v[2] = c8.out_valid; obs_b[2] = {c8.out_sel_err, c8.out_data};
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("sw%0d_ready", i), obs_rdy[i], q[i].size() < 2);
        chk($sformatf("sw%0d_valid", i), obs_v[i], q[i].size() > 0);
        if (q[i].size() > 0) chk($sformatf("sw%0d_beat", i), obs_b[i], q[i][0]);
        acc = v && (q[i].size() < 2);
        if (q[i].size() > 0 && r) void'(q[i].pop_front());
        if (acc) q[i].push_back(exp_b[i]);
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
